// File: rtl/mesh_arb_pkg.sv
// Shared types and packet layout for the mesh output arbiter and router route decode.
// Packet layout assumes the default 20-bit mesh packet; payload sits below the mode bit.
package mesh_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Header field positions inside a pckg_sz=20 packet (MSB first).
    localparam int NXT_JUMP_LSB = 12;
    localparam int NXT_JUMP_W   = 8;
    localparam int ID_ROW_LSB   = 8;
    localparam int ID_ROW_W     = 4;
    localparam int ID_COLUM_LSB = 4;
    localparam int ID_COLUM_W   = 4;
    localparam int MODE_BIT     = 3;

    function automatic logic [ID_ROW_W-1:0] pkt_id_row(input logic [19:0] pkt);
        return pkt[ID_ROW_LSB +: ID_ROW_W];
    endfunction

endpackage

// File: rtl/mesh_out_arbiter_if.sv
// Requester-side and downstream-side signals of one mesh output port.
// slave: the arbiter; master: requester FIFOs plus downstream consumer.
interface mesh_out_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int pckg_sz = 20
);
    logic [NUM_REQ-1:0]              pndng_in;
    logic [NUM_REQ-1:0]              route_req;
    logic [NUM_REQ-1:0][pckg_sz-1:0] data_in;
    logic [NUM_REQ-1:0]              pop_in;
    logic                            pndng_out;
    logic [pckg_sz-1:0]              data_out;
    logic                            pop_out;

    modport slave (
        input  pndng_in, route_req, data_in, pop_out,
        output pop_in, pndng_out, data_out
    );

    modport master (
        output pndng_in, route_req, data_in, pop_out,
        input  pop_in, pndng_out, data_out
    );
endinterface

// File: rtl/rr_prio_pick.sv
// Round-robin pick: first eligible index after ptr, via rotate / find-first / rotate back.
// Latency: combinational. Backpressure: none, pure function of elig and ptr.
// Notes: ptr values >= NUM_REQ-1 wrap the search start to index 0.
module rr_prio_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    int                   start_i;
    int                   k_i;
    int                   sum_i;

    always_comb begin
        start_i = (int'(ptr) >= NUM_REQ - 1) ? 0 : int'(ptr) + 1;
        dbl     = {elig, elig};
        rot     = dbl[start_i +: NUM_REQ];
        found   = 1'b0;
        k_i     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                k_i   = i;
            end
        end
        sum_i = start_i + k_i;
        if (sum_i >= NUM_REQ) sum_i = sum_i - NUM_REQ;
        win_idx = IDX_W'(sum_i);
        any     = found;
        win_oh  = found ? (NUM_REQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/mesh_out_arbiter.sv
// Round-robin arbiter sharing one mesh output link among NUM_REQ FIFOs; optional MESH_ARB_STATS_EN grant counters.
// Latency: pop_in in cycle N, pndng_out/data_out valid from N+1; 1 packet/cycle sustained.
// Backpressure: while the output register is full and pop_out is low, no requester is popped.
module mesh_out_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int pckg_sz = 20
) (
    input  logic clk,
    input  logic reset,
    mesh_out_arbiter_if.slave bus
`ifdef MESH_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0] grant_cnt
`endif
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         st, st_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [pckg_sz-1:0] data_q;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               any;
    logic               slot_free;
    logic               grant;

    assign elig = bus.pndng_in & bus.route_req;

    rr_prio_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .elig    (elig),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    // Gate on reset so no FIFO is popped while the arbiter is being cleared.
    assign slot_free     = (st == EMPTY) || bus.pop_out;
    assign grant         = reset && slot_free && any;
    assign bus.pop_in    = grant ? win_oh : '0;
    assign bus.pndng_out = (st == FULL);
    assign bus.data_out  = data_q;

    always_comb begin
        st_nxt = st;
        case (st)
            EMPTY:   if (grant) st_nxt = FULL;
            FULL:    if (bus.pop_out && !grant) st_nxt = EMPTY;
            default: st_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st     <= EMPTY;
            ptr    <= IDX_W'(NUM_REQ - 1);
            data_q <= '0;
        end else begin
            st <= st_nxt;
            if (grant) begin
                data_q <= bus.data_in[win_idx];
                ptr    <= win_idx;
            end
        end
    end

`ifdef MESH_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.pop_in[i] && (grant_cnt[i] != '1))
                    grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_mesh_out_arbiter.sv
// Directed bench for mesh_out_arbiter: reset, single grant, round robin, stall, ineligible, mid-transfer reset.
// Counter checks compile in only with MESH_ARB_STATS_EN.
module tb_mesh_out_arbiter;
    localparam int N  = 5;
    localparam int PW = 20;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mesh_out_arbiter_if #(.NUM_REQ(N), .pckg_sz(PW)) bus ();

`ifdef MESH_ARB_STATS_EN
    logic [N-1:0][15:0] grant_cnt;
`endif

    mesh_out_arbiter #(.NUM_REQ(N), .pckg_sz(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MESH_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

    initial begin
        reset         = 1'b0;
        bus.pndng_in  = '1;
        bus.route_req = '1;
        bus.pop_out   = 1'b1;
        for (int i = 0; i < N; i++) bus.data_in[i] = 20'h10000 + 20'(i);

        // Reset: pop_in forced low even with everything eligible
        #1;
        chk("rst_pop_in", 32'(bus.pop_in), 32'h0);
        tick();
        chk("rst_pndng_out", 32'(bus.pndng_out), 32'h0);
        chk("rst_data_out", 32'(bus.data_out), 32'h0);
        tick();

        // Single grant to requester 0
        reset         = 1'b1;
        bus.pndng_in  = 5'b00001;
        bus.data_in[0] = 20'hABCDE;
        #1;
        chk("first_pop_in", 32'(bus.pop_in), 32'h1);
        tick();
        bus.pndng_in = '0;
        #1;
        chk("first_pndng_out", 32'(bus.pndng_out), 32'h1);
        chk("first_data_out", 32'(bus.data_out), 32'hABCDE);
        chk("first_pop_in_after", 32'(bus.pop_in), 32'h0);
        tick();
        chk("drain_pndng_out", 32'(bus.pndng_out), 32'h0);
        chk("drain_data_hold", 32'(bus.data_out), 32'hABCDE);

        // Round robin, back-to-back, starting from reset priority
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.data_in[0] = 20'h10000;
        bus.pndng_in   = '1;
        bus.pop_out    = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            chk($sformatf("rr_pop_%0d", j), 32'(bus.pop_in), 32'(1) << order[j]);
            if (j > 0) begin
                chk($sformatf("rr_vld_%0d", j), 32'(bus.pndng_out), 32'h1);
                chk($sformatf("rr_dat_%0d", j), 32'(bus.data_out), 32'h10000 + 32'(order[j-1]));
            end
            tick();
        end

        // Stall while full
        bus.pop_out = 1'b0;
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("stall_pop_in", 32'(bus.pop_in), 32'h0);
            chk("stall_data", 32'(bus.data_out), 32'h10004);
            chk("stall_vld", 32'(bus.pndng_out), 32'h1);
            tick();
        end
        bus.pop_out = 1'b1;
        #1;
        chk("unstall_pop_in", 32'(bus.pop_in), 32'h1);
        tick();
        bus.pndng_in = '0;
        #1;
        chk("unstall_data", 32'(bus.data_out), 32'h10000);
        tick();

        // Requester 2 pending but not routed here
        bus.pndng_in  = 5'b00100;
        bus.route_req = 5'b11011;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("noroute_pop_in", 32'(bus.pop_in), 32'h0);
            chk("noroute_vld", 32'(bus.pndng_out), 32'h0);
            tick();
        end

        // Reset while full discards the packet
        bus.pndng_in  = '1;
        bus.route_req = '1;
        bus.pop_out   = 1'b0;
        #1;
        chk("prefull_pop_in", 32'(bus.pop_in), 32'h2);
        tick();
        chk("full_vld", 32'(bus.pndng_out), 32'h1);
        chk("full_data", 32'(bus.data_out), 32'h10001);
        reset       = 1'b0;
        bus.pop_out = 1'b1;
        #1;
        chk("midrst_pop_in", 32'(bus.pop_in), 32'h0);
        tick();
        chk("midrst_vld", 32'(bus.pndng_out), 32'h0);
        chk("midrst_data", 32'(bus.data_out), 32'h0);
        reset = 1'b1;
        #1;
        chk("postrst_pop_in", 32'(bus.pop_in), 32'h1);
        tick();
        chk("postrst_data", 32'(bus.data_out), 32'h10000);

`ifdef MESH_ARB_STATS_EN
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        bus.pndng_in = 5'b01000;
        bus.pop_out  = 1'b1;
        repeat (7) tick();
        bus.pndng_in = '0;
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("cnt_%0d", i), 32'(grant_cnt[i]), (i == 3) ? 32'd7 : 32'd0);
        bus.pndng_in = 5'b01000;
        repeat (65535 - 7) tick();
        bus.pndng_in = '0;
        #1;
        chk("cnt_full", 32'(grant_cnt[3]), 32'hFFFF);
        bus.pndng_in = 5'b01000;
        tick();
        bus.pndng_in = '0;
        #1;
        chk("cnt_sat", 32'(grant_cnt[3]), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mesh_out_arbiter.md
# mesh_out_arbiter

Round-robin output-port arbiter for one router port of the mesh (`mesh_gnrtr`). It shares a single outbound link among `NUM_REQ` input FIFOs (N, S, E, W, local terminal) using the mesh's `pndng`/`pop` FIFO-style handshake. Each granted packet is held in a one-entry output register until the downstream consumer pops it. Back-to-back transfers at one packet per cycle are supported.

## Interface
- `NUM_REQ`, 5: number of requesting input FIFOs (2..8).
- `pckg_sz`, 20: packet width in bits; matches the mesh `pckg_sz`.
- `clk`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  reset, synchronous, active-low.
- `pndng_in`  input  NUM_REQ  per-requester head-of-FIFO valid.
- `route_req`  input  NUM_REQ  per-requester flag that its head packet targets this port.
- `data_in`  input  NUM_REQ×pckg_sz  per-requester head packet.
- `pop_in`  output  NUM_REQ  one-hot pop to the winning requester FIFO.
- `pndng_out`  output  1  output register holds a valid packet.
- `data_out`  output  pckg_sz  output register contents.
- `pop_out`  input  1  downstream consumes `data_out` this cycle.
- `grant_cnt`  output  NUM_REQ×16  per-requester grant counters (present only with `MESH_ARB_STATS_EN`).

## Operation
- Eligible set: `elig = pndng_in & route_req`.
- Round-robin pointer `ptr` holds the last winner. The search starts at `ptr+1` modulo `NUM_REQ` and takes the first eligible index.
- The slot is free when `pndng_out==0`, or when `pndng_out==1 && pop_out==1`.
- States:
  - EMPTY (`pndng_out=0`).
  - FULL (`pndng_out=1`).
- EMPTY, slot free, `elig!=0`: assert `pop_in[w]` combinationally. On the edge, capture `data_in[w]` into `data_out`, set `ptr=w`, go to FULL.
- EMPTY, `elig==0`: stay in EMPTY. `data_out` holds its last value.
- FULL, `pop_out=0`: hold `data_out`. `pop_in` is all zero. Any new request waits.
- FULL, `pop_out=1`, `elig!=0`: pop the next winner and recapture in the same cycle. Stay in FULL with no bubble.
- FULL, `pop_out=1`, `elig==0`: go to EMPTY.
- `pop_in` is always one-hot or zero, and is never asserted for a non-eligible requester.
- `pop_out` while EMPTY is ignored; no state change.
- Reset (`reset==0` at an edge):
  - `pndng_out=0`, `data_out=0`.
  - `ptr=NUM_REQ-1`, so requester 0 has first priority.
  - Counters are cleared.
  - `pop_in` is forced to 0 combinationally while `reset` is low.
- Reset asserted mid-transfer discards the held packet. Requester FIFOs are not popped during reset.

## Timing
- Request to `pndng_out`: 1 cycle. `pop_in[w]` is in cycle N; `pndng_out`/`data_out` are valid from N+1.
- Combinational paths:
  - `pndng_in`/`route_req`/`pop_out` → `pop_in`.
  - No combinational path to `pndng_out` or `data_out`.
- Throughput: 1 packet/cycle when `pop_out` is held high and requests are continuous.
- Fairness: with all requesters eligible, each is granted exactly once in any `NUM_REQ` consecutive grants.

## Configuration
- `MESH_ARB_STATS_EN` defined:
  - The `grant_cnt` port exists.
  - Each 16-bit counter increments on every `pop_in[i]` and saturates at 16'hFFFF.
  - Counters are cleared by reset.
- Undefined: the port and counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package `mesh_arb_pkg`:
  - `arb_state_t` (EMPTY, FULL).
  - `STAT_W=16`.
  - Packet field offsets (`Nxt_jump`, `id_row`, `id_colum`, `mode`), shared with the router for route decode.
- Sub-module `rr_prio_pick`:
  - Combinational.
  - Inputs: `elig` and `ptr`.
  - Outputs: one-hot winner and its index, via a rotate, find-first, rotate-back scheme.

## Test plan
- After reset, set `elig=5'b00001`, `data_in[0]=20'hABCDE`, hold `pop_out=1`:
  - `pop_in=5'b00001` for one cycle.
  - Next cycle `pndng_out=1`, `data_out=20'hABCDE`.
- All 5 eligible continuously with `pop_out=1`:
  - Grant order is 0,1,2,3,4,0,...
  - One packet per cycle, no idle cycle.
- FULL with `pop_out=0` for 10 cycles while `elig=5'b11111`:
  - `pop_in` stays 0.
  - `data_out` is stable.
  - The first pop then grants `ptr+1`.
- `pndng_in=1` with `route_req=0` on requester 2 only: no pop, `pndng_out` stays 0.
- Reset pulsed while FULL with `pndng_out=1`: the next cycle shows `pndng_out=0`, `data_out=0`, and the first grant goes to requester 0.
- With `MESH_ARB_STATS_EN`, 7 grants to requester 3:
  - `grant_cnt[3]=7`, all others 0.
  - A counter preloaded to 16'hFFFF stays at 16'hFFFF on a further grant.
